display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexing controller for the board's 8-digit, common-anode seven-segment display. It accepts two 16-bit words from the processor side over a valid/ready handshake and applies new values only at frame boundaries, so the display never tears. It scans digits with a blanking gap between them to suppress ghosting, and drives the active-low segment and anode pins. It sits between the processor core's result registers and the board pins, on the undivided board clock.

## Interface
- DRIVE_CYCLES, 4000: cycles each digit is lit per slot (≥1).
- BLANK_CYCLES, 400: all-off cycles before each digit slot (≥1).
- Clk  in  1  board clock; one clock domain.
- Reset  in  1  synchronous, active-high.
- upd_valid  in  1  update request.
- upd_ready  out  1  controller can accept an update.
- upd_hi  in  16  left four digits (digit 7 = upd_hi[15:12]).
- upd_lo  in  16  right four digits (digit 0 = upd_lo[3:0]).
- upd_blank_lz  in  1  leading-zero blanking for this update.
- out7  out  7  segments {g,f,e,d,c,b,a}, active-low.
- en_out  out  8  anodes, active-low; bit i = digit i.
- frame_done  out  1  one-cycle pulse at end of digit-7 slot.

## Operation
- Update path:
  - An update is accepted when upd_valid && upd_ready.
  - Accept captures {upd_hi, upd_lo, upd_blank_lz} into a pending register and sets pend_full. upd_ready = !pend_full.
  - At the frame boundary (end of digit-7 DRIVE): if pend_full, pending is copied to active and pend_full clears.
- FSM states: BLANK, DRIVE.
  - After reset: BLANK, digit=0, counter=0.
  - BLANK: en_out=8'hFF, out7=7'h7F. After BLANK_CYCLES cycles, go to DRIVE.
  - DRIVE: en_out = ~(1<<digit), out7 = decode(nibble[digit]). After DRIVE_CYCLES cycles, digit = (digit+1) mod 8, then go to BLANK.
  - Digit 7→0 wrap is the frame boundary.
- Leading-zero blanking (active blank_lz only), applied per 4-digit group independently:
  - Digit d is blanked (out7=7'h7F, anode still enabled) if it and every higher digit in its group are zero.
  - Digits 0 and 4 are never blanked.
- Decode, hex, active-low: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Counter width: clog2(max(DRIVE_CYCLES, BLANK_CYCLES)); it resets to 0 on every state change.

## Timing
- Reset values:
  - out7=7'h7F, en_out=8'hFF, frame_done=0, upd_ready=1.
  - Active and pending registers = 0; active blank_lz=0.
- out7, en_out and frame_done are registered and change one cycle after the FSM state/digit change. They never glitch within a slot.
- Frame length = 8·(BLANK_CYCLES+DRIVE_CYCLES) cycles.
- frame_done is high exactly one cycle per frame, coincident with the first BLANK cycle of digit 0.
- Accept to visible: the values appear at the first DRIVE of digit 0 after the next frame boundary.
- Boundary conditions:
  - Accept on the same cycle as a boundary with pend_full=0: the data goes to pending and is applied at the following boundary.
  - Boundary while pend_full=1: transfer happens; upd_ready rises the next cycle.
  - upd_valid held while upd_ready=0: no effect; data must be held by the requester.
  - Reset mid-slot or mid-update: all state returns to reset values the next cycle, and any pending update is discarded.

## Structure
- Shared package/include `display_pkg`:
  - state encoding (BLANK, DRIVE);
  - SEG_OFF=7'h7F and ANODES_OFF=8'hFF;
  - the 16-entry segment constant table.
- Sub-module `hex_to_seg7`: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.
- Top-level contains:
  - the handshake and pending/active registers;
  - the FSM and counter;
  - the blanking logic;
  - the output registers.

## Test plan
All scenarios use DRIVE_CYCLES=4, BLANK_CYCLES=2, giving a 48-cycle frame.
- Reset: assert Reset 3 cycles → out7=7'h7F, en_out=8'hFF, upd_ready=1, frame_done=0. The first DRIVE on digit 0 shows 7'h40.
- Scan: accept hi=16'h1234, lo=16'hABCD → from the following frame, digits 0..7 show 21,46,03,08,19,30,24,79. en_out walks FE,FD,…,7F with 2 cycles of FF between slots. frame_done pulses every 48 cycles.
- Backpressure: accept hi=16'h1111, then hold upd_valid with hi=16'h2222 → upd_ready=0 until the boundary. The second update is accepted after the boundary. 1111 is displayed for exactly one full frame before 2222.
- Leading zeros: hi=16'h0000, lo=16'h00F0, blank_lz=1 → digits 7,6,5 and 3,2 show 7F with their anodes enabled. Digit 4 shows 40, digit 1 shows 0E, digit 0 shows 40. The same data with blank_lz=0 shows 40 on all zero digits.
- Same-cycle accept and boundary: assert upd_valid on the cycle digit-7 DRIVE ends → the data is not shown in the next frame but is shown in the one after it.
- Mid-frame reset: a pending update is held and Reset is asserted during digit-3 DRIVE → next cycle outputs return to reset values. After reset the display shows all zeros and upd_ready=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents: scan FSM state encoding, all-off segment/anode patterns and the
// active-low hex segment table ({g,f,e,d,c,b,a}, bit = 0 lights the segment).
package display_pkg;

  typedef enum logic {
    StBlank = 1'b0,
    StDrive = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [7:0] ANODES_OFF = 8'hFF;

  // Entry i is the pattern for hex digit i (listed from F down to 0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Update handshake between the processor side and the display scan controller.
// Signals:
//   upd_valid     requester has an update
//   upd_ready     controller can take an update
//   upd_hi        digits 7..4 (digit 7 in [15:12])
//   upd_lo        digits 3..0 (digit 0 in [3:0])
//   upd_blank_lz  leading-zero blanking for this update
interface display_scan_ctrl_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_hi;
  logic [15:0] upd_lo;
  logic        upd_blank_lz;

  modport master (
    output upd_valid,
    output upd_hi,
    output upd_lo,
    output upd_blank_lz,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_hi,
    input  upd_lo,
    input  upd_blank_lz,
    output upd_ready
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports:
//   nibble  in  4  hex value
//   seg     out 7  {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Updates are taken over a valid/ready handshake into a pending buffer and
// promoted to the displayed value only at the frame boundary (end of the
// digit-7 drive slot), so a frame never mixes old and new data. Each digit
// slot is preceded by an all-off blanking gap to suppress ghosting.
// Ports:
//   clk         in   board clock
//   reset       in   synchronous, active-high
//   upd         slave modport of display_scan_ctrl_if (update handshake)
//   out7        out  segments {g,f,e,d,c,b,a}, active-low, registered
//   en_out      out  anodes, active-low, bit i = digit i, registered
//   frame_done  out  one-cycle pulse with the first blank cycle of digit 0
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DRIVE_CYCLES = 4000,
  parameter int unsigned BLANK_CYCLES = 400
) (
  input  logic                      clk,
  input  logic                      reset,
  display_scan_ctrl_if.slave        upd,
  output logic [6:0]                out7,
  output logic [7:0]                en_out,
  output logic                      frame_done
);

  localparam int unsigned MaxCycles = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(DRIVE_CYCLES - 1);

  // Update buffers
  logic [15:0] pend_hi_q, pend_lo_q, act_hi_q, act_lo_q;
  logic        pend_lz_q, act_lz_q, pend_full_q;

  // Scan state
  scan_state_e     state_q;
  logic [2:0]      digit_q;
  logic [CntW-1:0] cnt_q;
  logic            wrap_q;

  // Output registers
  logic [6:0] out7_q, out7_d;
  logic [7:0] en_out_q, en_out_d;
  logic       frame_done_q;

  logic        accept, blank_done, drive_done, boundary;
  logic [31:0] disp_word;
  logic [3:0]  nibble;
  logic [6:0]  seg_raw;
  logic        lz_blank;

  assign upd.upd_ready = ~pend_full_q;
  assign accept        = upd.upd_valid & ~pend_full_q;

  assign blank_done = (state_q == StBlank) && (cnt_q == BlankLast);
  assign drive_done = (state_q == StDrive) && (cnt_q == DriveLast);
  assign boundary   = drive_done && (digit_q == 3'd7);

  // Handshake and pending/active buffers. Accept and transfer are mutually
  // exclusive because accept needs an empty pending buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_lz_q   <= 1'b0;
      pend_full_q <= 1'b0;
      act_hi_q    <= '0;
      act_lo_q    <= '0;
      act_lz_q    <= 1'b0;
    end else begin
      if (boundary && pend_full_q) begin
        act_hi_q    <= pend_hi_q;
        act_lo_q    <= pend_lo_q;
        act_lz_q    <= pend_lz_q;
        pend_full_q <= 1'b0;
      end
      if (accept) begin
        pend_hi_q   <= upd.upd_hi;
        pend_lo_q   <= upd.upd_lo;
        pend_lz_q   <= upd.upd_blank_lz;
        pend_full_q <= 1'b1;
      end
    end
  end

  assign disp_word = {act_hi_q, act_lo_q};
  assign nibble    = disp_word[{digit_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // Blank a digit when it and every higher digit of its 4-digit group are
  // zero; the lowest digit of each group always shows.
  always_comb begin
    lz_blank = 1'b0;
    if (act_lz_q && (digit_q[1:0] != 2'd0)) begin
      lz_blank = 1'b1;
      for (int p = 0; p < 4; p++) begin
        if ((p >= int'(digit_q[1:0])) &&
            (disp_word[{digit_q[2], p[1:0], 2'b00} +: 4] != 4'h0)) begin
          lz_blank = 1'b0;
        end
      end
    end
  end

  always_comb begin
    out7_d   = SEG_OFF;
    en_out_d = ANODES_OFF;
    if (state_q == StDrive) begin
      en_out_d = ~(8'b1 << digit_q);
      out7_d   = lz_blank ? SEG_OFF : seg_raw;
    end
  end

  // Scan FSM, counter and output registers. Outputs lag the state by one
  // cycle; wrap_q delays frame_done by the same amount so it lines up with
  // the first visible blank cycle of digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBlank;
      digit_q      <= 3'd0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
      out7_q       <= SEG_OFF;
      en_out_q     <= ANODES_OFF;
      frame_done_q <= 1'b0;
    end else begin
      wrap_q       <= boundary;
      frame_done_q <= wrap_q;
      out7_q       <= out7_d;
      en_out_q     <= en_out_d;
      unique case (state_q)
        StBlank: begin
          if (blank_done) begin
            state_q <= StDrive;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrive: begin
          if (drive_done) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            digit_q <= digit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign out7       = out7_q;
  assign en_out     = en_out_q;
  assign frame_done = frame_done_q;

endmodule
